// File: rtl/mem_arbiter_fsm.sv
// mem_arbiter_fsm: sequenced arbiter sharing one single-ported RAM between
// the instruction-fetch requester and the data (load/store) requester.
// Data has priority. A saturating starvation counter forces an instruction
// grant after STARVE_MAX consecutive data grants while i_req is waiting.
// Completion is a registered one-cycle ready pulse to the owning requester.
//
// Optional feature: define MEMARB_TIMEOUT_EN to abort transfers that see
// ram_busy for TIMEOUT_CYC cycles. An aborted transfer returns rdata=0 and
// sets the sticky timeout_err flag.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer; arbitrate pending requests
// GNT_I | instruction read on the RAM port, waiting out ram_busy
// GNT_D | data read/write on the RAM port, waiting out ram_busy
// RESP  | ready pulse + rdata to the owner, RAM enables low
module mem_arbiter_fsm #(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TO_LIM     = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      next_state;

  // Transfer registers latched at grant; owner 1 = data requester.
  logic        lat_owner;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] resp_data;
  logic [2:0]  starve_cnt;

  logic        d_pend;
  logic        starve_ok;
  logic        grant_i;
  logic        grant_d;
  logic        capture;
  logic        in_gnt;
  logic        to_hit;

  assign d_pend    = d_ren | d_wen;
  assign starve_ok = ({1'b0, starve_cnt} < STARVE_LIM);
  assign in_gnt    = (state == GNT_I) || (state == GNT_D);

  // State register; async reset also drops the RAM enables immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic, grant/capture strobes and all outputs.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    capture    = 1'b0;
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = 32'h0;
    ram_wdata  = 32'h0;
    i_ready    = 1'b0;
    i_rdata    = 32'h0;
    d_ready    = 1'b0;
    d_rdata    = 32'h0;

    case (state)
      IDLE: begin
        if (d_pend && starve_ok) begin
          grant_d    = 1'b1;
          next_state = GNT_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          next_state = GNT_I;
        end else if (d_pend) begin
          grant_d    = 1'b1;
          next_state = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        ram_ren   = ~lat_wr;
        ram_wen   = lat_wr;
        ram_addr  = lat_addr;
        ram_wdata = lat_wdata;
        if (!ram_busy) begin
          capture    = 1'b1;
          next_state = RESP;
        end else if (to_hit) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (lat_owner) begin
          d_ready = 1'b1;
          d_rdata = resp_data;
        end else begin
          i_ready = 1'b1;
          i_rdata = resp_data;
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the winning request; a simultaneous read+write is a write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_owner <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else if (grant_d) begin
      lat_owner <= 1'b1;
      lat_wr    <= d_wen;
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
    end else if (grant_i) begin
      lat_owner <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= i_addr;
      lat_wdata <= 32'h0;
    end
  end

  // Response data: read data on completion, zero for writes and aborts.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        resp_data <= 32'h0;
    else if (capture) resp_data <= lat_wr ? 32'h0 : ram_rdata;
    else if (to_hit)  resp_data <= 32'h0;
  end

  // Starvation counter: counts data grants that bypassed a waiting i_req.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      starve_cnt <= 3'd0;
    else if (grant_i)
      starve_cnt <= 3'd0;
    else if (grant_d && i_req && (starve_cnt != 3'd7))
      starve_cnt <= starve_cnt + 3'd1;
  end

`ifdef MEMARB_TIMEOUT_EN
  logic [7:0] busy_cnt;
  logic       err_q;

  assign to_hit      = in_gnt & ram_busy & (busy_cnt == TO_LIM);
  assign timeout_err = err_q;

  // Busy-cycle counter per transfer and sticky timeout flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      if (grant_i || grant_d)
        busy_cnt <= 8'd0;
      else if (in_gnt && ram_busy && !to_hit)
        busy_cnt <= busy_cnt + 8'd1;
      if (to_hit)
        err_q <= 1'b1;
    end
  end
`else
  // Without the timeout the limit has no consumer.
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TO_LIM;
  assign to_hit             = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter_fsm.md
# mem_arbiter_fsm

Sequenced arbiter sharing the single-ported RAM between the instruction-fetch requester and the data requester. It latches each request, holds the RAM port stable for the whole transfer and waits out `ram_busy`. It returns read data through a registered one-cycle `ready` pulse. Data requests have priority, and a starvation counter guarantees instruction forward progress. The block sits between the core's fetch/LSU stages and the RAM model.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive data grants allowed while `i_req` is pending before instruction is forced.
- `TIMEOUT_CYC`, default 255: busy cycles tolerated per transfer; used only with the timeout feature.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `i_req` in 1: instruction read request, held until `i_ready`.
- `i_addr` in 32: instruction address.
- `i_ready` out 1: one-cycle completion pulse for the instruction requester.
- `i_rdata` out 32: instruction read data, valid with `i_ready`.
- `d_ren` in 1: data read request, held until `d_ready`.
- `d_wen` in 1: data write request, held until `d_ready`.
- `d_addr` in 32: data address.
- `d_wdata` in 32: data write data.
- `d_ready` out 1: one-cycle completion pulse for the data requester.
- `d_rdata` out 32: data read data, valid with `d_ready`; 0 for writes.
- `ram_ren` out 1: RAM read enable.
- `ram_wen` out 1: RAM write enable.
- `ram_addr` out 32: RAM address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data.
- `ram_busy` in 1: RAM not finished this cycle.
- `timeout_err` out 1: sticky transfer-timeout flag.

## Operation
- States: IDLE, GNT_I, GNT_D, RESP.
- IDLE arbitration:
  - If a data request (`d_ren|d_wen`) is pending and `starve_cnt < STARVE_MAX`, go to GNT_D.
  - Otherwise, if `i_req` is pending, go to GNT_I.
  - Otherwise, if a data request is pending, go to GNT_D.
- On a grant, latch the address, write data, operation and owner into registers. Requester inputs are not observed again until the next IDLE.
- `d_ren` and `d_wen` asserted together: treated as a write. `ram_ren`=0.
- `starve_cnt`:
  - 3 bits, saturating.
  - +1 on each GNT_D entry while `i_req`=1.
  - Cleared on GNT_I entry.
  - Unchanged otherwise.
- GNT_I/GNT_D drive the `ram_*` signals from the latched registers. Exactly one of `ram_ren`/`ram_wen` is 1.
  - If `ram_busy`=1, stay in the state with all RAM outputs held stable.
  - If `ram_busy`=0, capture `ram_rdata` (reads only; writes capture 0) into the response register and go to RESP.
- RESP: the owner's `ready`=1 and its `rdata`=captured value; `ram_ren`=`ram_wen`=0. Next state is IDLE unconditionally.
- Requests still high in the IDLE cycle after RESP are treated as new requests.
- Outside GNT states: `ram_ren`=`ram_wen`=0, `ram_addr`=0, `ram_wdata`=0.
- `i_rdata`/`d_rdata` are 0 except in the RESP cycle of their owner.

## Timing
- Reset: every output 0, state IDLE, `starve_cnt`=0, latched registers 0, `timeout_err`=0.
- Reset asserted mid-transfer drops `ram_ren`/`ram_wen` asynchronously; the transfer is abandoned and no `ready` is issued.
- Minimum latency:
  - Request seen in IDLE at cycle 0.
  - GNT at cycle 1.
  - `ready` at cycle 2 when `ram_busy`=0 in cycle 1.
  - Each busy cycle adds 1.
- Back-to-back transfers for one requester occur no more often than every 3 cycles.
- A single data requester is always serviced. `i_req` waits at most `STARVE_MAX` data transfers.
- Holding `ram_busy` high indefinitely stalls the block indefinitely unless the timeout feature is enabled.

## Configuration
- `MEMARB_TIMEOUT_EN` defined:
  - An 8-bit counter counts GNT cycles with `ram_busy`=1; it clears on grant entry.
  - When the count reaches `TIMEOUT_CYC`, the transfer aborts: enables drop, the state goes to RESP, the owner gets `ready` with `rdata`=0, and `timeout_err` is set.
  - `timeout_err` clears only on reset.
- `MEMARB_TIMEOUT_EN` undefined: no counter; `timeout_err` is tied 0; GNT waits forever on busy.

## Test plan
- Instruction read: `i_req`=1, `i_addr`=0x40, `ram_busy`=0, `ram_rdata`=0x00A00093 → `ram_ren`=1 with `ram_addr`=0x40 in cycle 1; `i_ready`=1 with `i_rdata`=0x00A00093 in cycle 2 only.
- Write with busy: `d_wen`=1, `d_addr`=0x100, `d_wdata`=0xCAFEF00D, `ram_busy` high for 3 cycles → `ram_wen`/`ram_addr`/`ram_wdata` stable for 4 cycles; `d_ready`=1 in cycle 5 with `d_rdata`=0.
- Simultaneous `i_req` and `d_ren` at reset exit → data is granted first; instruction is granted in the IDLE following `d_ready`.
- Starvation: `i_req` held and `d_ren` re-asserted continuously → exactly 4 data transfers, then an instruction transfer, then data resumes with `starve_cnt`=0.
- Reset: `nRST` pulled low during GNT_D with busy=1 → `ram_wen`=0 immediately, no `d_ready`, state IDLE after release.
- Timeout (`MEMARB_TIMEOUT_EN`): `d_ren` with `ram_busy` stuck 1 → `d_ready`=1 with `d_rdata`=0 after 255 busy cycles plus RESP; `timeout_err`=1 and remains 1 through later transfers.
